// File: rtl/cmd_packet_decoder_if.sv
// Byte-in / command-out bundle of the host command decoder.
// master = decoder side, slave = the UART/register-file side that drives bytes and consumes commands.
interface cmd_packet_decoder_if #(
    parameter int unsigned PAYLOAD_BYTES = 4
);
    logic                         byte_in_ready;
    logic [7:0]                   byte_in;
    logic                         cmd_ready;
    logic                         cmd_valid;
    logic [7:0]                   opcode;
    logic [8*PAYLOAD_BYTES-1:0]   command;
    logic                         is_long;
    logic                         timeout_err;
    logic                         overrun_err;

    modport master (
        input  byte_in_ready, byte_in, cmd_ready,
        output cmd_valid, opcode, command, is_long, timeout_err, overrun_err
    );

    modport slave (
        output byte_in_ready, byte_in, cmd_ready,
        input  cmd_valid, opcode, command, is_long, timeout_err, overrun_err
    );
endinterface

// File: rtl/cmd_packet_decoder.sv
// SUMP-style host command assembler: opcode byte plus optional MSB-first payload,
// presented on a valid/ready handshake with inter-byte timeout and overrun pulses.
module cmd_packet_decoder #(
    parameter int unsigned PAYLOAD_BYTES  = 4,
    parameter int unsigned LONG_BIT       = 7,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clock,
    input  logic                 reset,
    cmd_packet_decoder_if.master bus
);
    localparam int unsigned SHW = 8 * PAYLOAD_BYTES;
    localparam int unsigned BCW = $clog2(PAYLOAD_BYTES + 1);
    localparam int unsigned TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_VALID
    } state_t;

    state_t           state_q;
    logic [BCW-1:0]   cnt_q;
    logic [TCW-1:0]   tmo_q;
    logic [TCW-1:0]   tmo_d;
    logic [7:0]       sh_op_q;
    logic [SHW-1:0]   sh_pl_q;
    logic [SHW-1:0]   sh_pl_d;
    logic             valid_q;
    logic [7:0]       opcode_q;
    logic [SHW-1:0]   command_q;
    logic             is_long_q;
    logic             tmo_err_q;
    logic             ovr_err_q;

    logic             last_byte;
    logic             tmo_expire;
    logic             take_opcode;

    always_comb begin
        // Truncating cast drops the oldest byte, which also covers PAYLOAD_BYTES = 1.
        sh_pl_d     = SHW'({sh_pl_q, bus.byte_in});
        tmo_d       = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
        last_byte   = (cnt_q == BCW'(PAYLOAD_BYTES - 1));
        tmo_expire  = (TIMEOUT_CYCLES > 0) && (tmo_q == TCW'(TIMEOUT_CYCLES - 1));
        take_opcode = bus.byte_in_ready &&
                      ((state_q == S_IDLE) || ((state_q == S_VALID) && bus.cmd_ready));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            sh_op_q   <= '0;
            sh_pl_q   <= '0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            command_q <= '0;
            is_long_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;

            case (state_q)
                S_PAYLOAD: begin
                    if (bus.byte_in_ready) begin
                        sh_pl_q <= sh_pl_d;
                        cnt_q   <= cnt_q + 1'b1;
                        tmo_q   <= '0;
                        if (last_byte) begin
                            state_q   <= S_VALID;
                            valid_q   <= 1'b1;
                            opcode_q  <= sh_op_q;
                            command_q <= sh_pl_d;
                            is_long_q <= 1'b1;
                        end
                    end else if (tmo_expire) begin
                        state_q   <= S_IDLE;
                        tmo_err_q <= 1'b1;
                        tmo_q     <= '0;
                        sh_op_q   <= '0;
                        sh_pl_q   <= '0;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        tmo_q <= tmo_d;
                    end
                end
                S_VALID: begin
                    if (bus.cmd_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (bus.byte_in_ready) begin
                        ovr_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Opcode intake is shared by IDLE and the handshake cycle of VALID;
            // placed last so it overrides the handshake's drop of cmd_valid.
            if (take_opcode) begin
                sh_op_q <= bus.byte_in;
                if (bus.byte_in[LONG_BIT]) begin
                    state_q <= S_PAYLOAD;
                    cnt_q   <= '0;
                    tmo_q   <= '0;
                end else begin
                    state_q   <= S_VALID;
                    valid_q   <= 1'b1;
                    opcode_q  <= bus.byte_in;
                    command_q <= '0;
                    is_long_q <= 1'b0;
                end
            end
        end
    end

    assign bus.cmd_valid   = valid_q;
    assign bus.opcode      = opcode_q;
    assign bus.command     = command_q;
    assign bus.is_long     = is_long_q;
    assign bus.timeout_err = tmo_err_q;
    assign bus.overrun_err = ovr_err_q;
endmodule

// File: tb/tb_cmd_packet_decoder.sv
// Bench for cmd_packet_decoder: three configurations driven by one byte stream,
// each checked every cycle against a byte-accumulator reference model, plus directed checks.
module tb_cmd_packet_decoder;
    logic       clk;
    logic       rst;
    logic       stb;
    logic [7:0] bin;
    logic       rdy;

    int n_checks = 0;
    int n_errors = 0;

    // Configurations: A = 4 bytes/bit7/timeout 16, B = 1 byte/bit6/timeout 5, C = 8 bytes/bit7/no timeout
    int pbs[3] = '{4, 1, 8};
    int lbs[3] = '{7, 6, 7};
    int tos[3] = '{16, 5, 0};

    cmd_packet_decoder_if #(.PAYLOAD_BYTES(4)) ifa ();
    cmd_packet_decoder_if #(.PAYLOAD_BYTES(1)) ifb ();
    cmd_packet_decoder_if #(.PAYLOAD_BYTES(8)) ifc ();

    assign ifa.byte_in_ready = stb;
    assign ifa.byte_in       = bin;
    assign ifa.cmd_ready     = rdy;
    assign ifb.byte_in_ready = stb;
    assign ifb.byte_in       = bin;
    assign ifb.cmd_ready     = rdy;
    assign ifc.byte_in_ready = stb;
    assign ifc.byte_in       = bin;
    assign ifc.cmd_ready     = rdy;

    cmd_packet_decoder #(.PAYLOAD_BYTES(4), .LONG_BIT(7), .TIMEOUT_CYCLES(16)) dut_a (
        .clock(clk), .reset(rst), .bus(ifa)
    );
    cmd_packet_decoder #(.PAYLOAD_BYTES(1), .LONG_BIT(6), .TIMEOUT_CYCLES(5)) dut_b (
        .clock(clk), .reset(rst), .bus(ifb)
    );
    cmd_packet_decoder #(.PAYLOAD_BYTES(8), .LONG_BIT(7), .TIMEOUT_CYCLES(0)) dut_c (
        .clock(clk), .reset(rst), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: a command is an opcode plus an accumulated payload value.
    bit          m_collect [3];
    int          m_n       [3];
    int          m_idle    [3];
    logic [63:0] m_acc     [3];
    logic [7:0]  m_op      [3];
    logic        e_valid   [3];
    logic [7:0]  e_opcode  [3];
    logic [63:0] e_cmd     [3];
    logic        e_long    [3];
    logic        e_tmo     [3];
    logic        e_ovr     [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_collect[k] = 0; m_n[k] = 0; m_idle[k] = 0; m_acc[k] = 0; m_op[k] = 0;
            e_valid[k] = 0; e_opcode[k] = 0; e_cmd[k] = 0; e_long[k] = 0;
            e_tmo[k] = 0; e_ovr[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic s, input logic [7:0] b, input logic r);
        bit take;
        take     = 0;
        e_tmo[k] = 0;
        e_ovr[k] = 0;
        if (e_valid[k]) begin
            if (r) begin
                e_valid[k] = 0;
                take = s;
            end else if (s) begin
                e_ovr[k] = 1;
            end
        end else if (m_collect[k]) begin
            if (s) begin
                m_acc[k] = (m_acc[k] << 8) | 64'(b);
                m_n[k]++;
                m_idle[k] = 0;
                if (m_n[k] == pbs[k]) begin
                    m_collect[k] = 0;
                    e_valid[k] = 1; e_opcode[k] = m_op[k]; e_cmd[k] = m_acc[k]; e_long[k] = 1;
                end
            end else if (tos[k] > 0) begin
                m_idle[k]++;
                if (m_idle[k] == tos[k]) begin
                    m_collect[k] = 0;
                    e_tmo[k] = 1;
                end
            end
        end else begin
            take = s;
        end
        if (take) begin
            if (b[lbs[k]]) begin
                m_collect[k] = 1; m_op[k] = b; m_n[k] = 0; m_acc[k] = 0; m_idle[k] = 0;
            end else begin
                e_valid[k] = 1; e_opcode[k] = b; e_cmd[k] = 0; e_long[k] = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else for (int k = 0; k < 3; k++) model_step(k, stb, bin, rdy);
    end

    task automatic check_inst(input int k, input logic v, input logic [7:0] op,
                              input logic [63:0] cmd, input logic lg, input logic te,
                              input logic oe);
        check($sformatf("m%0d.valid", k), 64'(v), 64'(e_valid[k]));
        check($sformatf("m%0d.opcode", k), 64'(op), 64'(e_opcode[k]));
        check($sformatf("m%0d.command", k), cmd, e_cmd[k]);
        check($sformatf("m%0d.is_long", k), 64'(lg), 64'(e_long[k]));
        check($sformatf("m%0d.timeout_err", k), 64'(te), 64'(e_tmo[k]));
        check($sformatf("m%0d.overrun_err", k), 64'(oe), 64'(e_ovr[k]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_inst(0, ifa.cmd_valid, ifa.opcode, 64'(ifa.command), ifa.is_long,
                       ifa.timeout_err, ifa.overrun_err);
            check_inst(1, ifb.cmd_valid, ifb.opcode, 64'(ifb.command), ifb.is_long,
                       ifb.timeout_err, ifb.overrun_err);
            check_inst(2, ifc.cmd_valid, ifc.opcode, ifc.command, ifc.is_long,
                       ifc.timeout_err, ifc.overrun_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the strobe was sampled.
    task automatic strobe(input logic [7:0] b);
        stb = 1'b1;
        bin = b;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".valid"},   64'(ifa.cmd_valid),   64'h0);
        check({tag, ".opcode"},  64'(ifa.opcode),      64'h0);
        check({tag, ".command"}, 64'(ifa.command),     64'h0);
        check({tag, ".is_long"}, 64'(ifa.is_long),     64'h0);
        check({tag, ".tmo"},     64'(ifa.timeout_err), 64'h0);
        check({tag, ".ovr"},     64'(ifa.overrun_err), 64'h0);
    endtask

    initial begin
        int p;
        rst = 1'b1;
        stb = 1'b0;
        bin = 8'h00;
        rdy = 1'b0;
        #1;
        check_a_zero("reset");
        check("reset.c_command", ifc.command, 64'h0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Long command
        rdy = 1'b1;
        strobe(8'h82); strobe(8'h12); strobe(8'h34); strobe(8'h56); strobe(8'h78);
        check("long.valid",   64'(ifa.cmd_valid), 64'h1);
        check("long.opcode",  64'(ifa.opcode),    64'h82);
        check("long.command", 64'(ifa.command),   64'h12345678);
        check("long.is_long", 64'(ifa.is_long),   64'h1);
        tick(1);
        check("long.drop", 64'(ifa.cmd_valid), 64'h0);

        // Short command under back-pressure, with an overrun
        rdy = 1'b0;
        strobe(8'h01);
        check("short.valid",   64'(ifa.cmd_valid), 64'h1);
        check("short.opcode",  64'(ifa.opcode),    64'h01);
        check("short.is_long", 64'(ifa.is_long),   64'h0);
        tick(3);
        strobe(8'h11);
        check("ovr.pulse",  64'(ifa.overrun_err), 64'h1);
        check("ovr.opcode", 64'(ifa.opcode),      64'h01);
        tick(1);
        check("ovr.once",  64'(ifa.overrun_err), 64'h0);
        check("ovr.valid", 64'(ifa.cmd_valid),   64'h1);
        tick(4);
        rdy = 1'b1;
        tick(1);
        check("short.drop", 64'(ifa.cmd_valid), 64'h0);

        // Timeout after 16 idle cycles
        strobe(8'hC0); strobe(8'hAA);
        tick(15);
        check("tmo.early", 64'(ifa.timeout_err), 64'h0);
        tick(1);
        check("tmo.pulse", 64'(ifa.timeout_err), 64'h1);
        check("tmo.valid", 64'(ifa.cmd_valid),   64'h0);
        tick(1);
        check("tmo.once", 64'(ifa.timeout_err), 64'h0);
        rdy = 1'b0;
        strobe(8'h02);
        check("after_tmo.opcode", 64'(ifa.opcode), 64'h02);

        // Handshake and new short opcode in the same cycle
        tick(2);
        check("b2b.first", 64'(ifa.opcode), 64'h02);
        rdy = 1'b1;
        strobe(8'h03);
        check("b2b.valid",  64'(ifa.cmd_valid), 64'h1);
        check("b2b.opcode", 64'(ifa.opcode),    64'h03);
        tick(1);

        // Asynchronous reset mid-command
        strobe(8'h80); strobe(8'h11);
        #2 rst = 1'b1;
        #1 check_a_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        strobe(8'h80); strobe(8'h01); strobe(8'h02); strobe(8'h03); strobe(8'h04);
        check("post_rst.command", 64'(ifa.command), 64'h01020304);
        tick(2);

        // Randomized traffic with bursty strobe density
        for (int blk = 0; blk < 60; blk++) begin
            case ($urandom_range(2, 0))
                0:       p = 4;
                1:       p = 40;
                default: p = 90;
            endcase
            for (int c = 0; c < 50; c++) begin
                stb = ($urandom_range(99, 0) < p);
                bin = 8'($urandom);
                rdy = ($urandom_range(99, 0) < 70);
                @(negedge clk);
            end
        end
        stb = 1'b0;
        rdy = 1'b1;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cmd_packet_decoder.md
Name: cmd_packet_decoder

Overview:
- Parametrised successor of the logic analyser's host command decoder; sits between the UART byte receiver and the capture-control register file.
- Assembles SUMP-style commands: one opcode byte; short opcodes carry no payload, long opcodes carry PAYLOAD_BYTES payload bytes, MSB first.
- Adds a valid/ready output handshake, an inter-byte timeout that discards partial commands, and overrun reporting.

Parameters:
- PAYLOAD_BYTES, 4, payload bytes per long command (1..8).
- LONG_BIT, 7, opcode bit index selecting long (1) vs short (0) command.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between payload bytes; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte_in_ready  in  1  one-cycle strobe; byte_in is valid this cycle.
- byte_in  in  8  received byte.
- cmd_ready  in  1  downstream accepts the command when high with cmd_valid.
- cmd_valid  out  1  a complete command is presented.
- opcode  out  8  opcode of the presented command.
- command  out  8*PAYLOAD_BYTES  payload of the presented command. First payload byte is in the top byte. Zero for short commands.
- is_long  out  1  presented command is long.
- timeout_err  out  1  one-cycle pulse: partial command discarded by timeout.
- overrun_err  out  1  one-cycle pulse: byte dropped because a command is pending.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, active-high):
  - state = IDLE.
  - All outputs are 0: cmd_valid, opcode, command, is_long, timeout_err and overrun_err.
  - Byte counter, timeout counter and shadow payload register are 0.
- States: IDLE, PAYLOAD, VALID.
- IDLE:
  - On byte_in_ready, capture byte_in as the shadow opcode.
  - If byte_in[LONG_BIT] = 1: go to PAYLOAD, clear the byte counter and the timeout counter.
  - If byte_in[LONG_BIT] = 0: go to VALID. Load opcode = byte, command = 0, is_long = 0, and set cmd_valid = 1 on the next edge. Latency is 1 clock.
- PAYLOAD:
  - Each byte_in_ready shifts the byte into the shadow payload: shadow = {shadow[8*PAYLOAD_BYTES-9:0], byte_in}. Increment the byte counter and clear the timeout counter.
  - When the byte accepted is number PAYLOAD_BYTES, go to VALID. Load opcode and command from the shadow registers including this byte, set is_long = 1 and cmd_valid = 1. Latency from the last byte strobe to cmd_valid is 1 clock.
  - If no strobe arrives, increment the timeout counter. When it reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES > 0), go to IDLE, pulse timeout_err for 1 cycle, and clear the shadow registers. Outputs keep their previous values.
  - A strobe in the same cycle the counter would expire wins: the byte is accepted and there is no timeout.
- VALID:
  - cmd_valid, opcode, command and is_long stay stable until cmd_valid && cmd_ready.
  - On the handshake, cmd_valid drops on the next edge. If byte_in_ready is also high in that cycle, the byte is processed exactly as in IDLE; a short opcode re-asserts cmd_valid with no gap.
  - A byte_in_ready in VALID with cmd_ready low is dropped and overrun_err pulses for 1 cycle. State is unchanged.
- Counter widths: the byte counter is $clog2(PAYLOAD_BYTES+1) bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates. There is no wrap-around.
- Reset mid-command: the partial command is discarded immediately; no pulse is generated.
- cmd_ready is ignored while cmd_valid = 0.

Test Plan:
- Long command: strobes 0x82, 0x12, 0x34, 0x56, 0x78 with cmd_ready = 1 -> 1 clock after the 0x78 strobe: cmd_valid = 1 for 1 cycle, opcode = 0x82, command = 0x12345678, is_long = 1.
- Short command and back-pressure: strobe 0x01 with cmd_ready = 0 for 10 cycles -> cmd_valid high and stable with opcode = 0x01, command = 0, is_long = 0; asserting cmd_ready drops cmd_valid on the next edge. A strobe 0x11 during the wait -> overrun_err pulses once and the outputs are unchanged.
- Timeout, with TIMEOUT_CYCLES = 16: strobes 0xC0, 0xAA, then silence -> timeout_err pulses exactly 16 cycles after the 0xAA strobe; cmd_valid never rises. A following 0x02 short command is decoded correctly.
- Simultaneous handshake and byte: while the 0x02 command is pending, assert cmd_ready together with strobe 0x03 -> cmd_valid stays high, and opcode changes 0x02 -> 0x03 on consecutive cycles.
- Reset mid-operation: strobes 0x80, 0x11, then assert reset asynchronously between clock edges -> all outputs are 0 immediately. After release, 0x80 0x01 0x02 0x03 0x04 gives command = 0x01020304.
- Parameter sweep: PAYLOAD_BYTES = 1 and 8, and LONG_BIT = 6 -> payload order and width are correct. Opcode 0x40 is long when LONG_BIT = 6; opcode 0x80 is short when LONG_BIT = 6.
